// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB instruction controller: op types, FSM states,
// INVTLB limit, ELO entry-low layout and page-size constants.
package tlb_op_ctrl_pkg;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

    localparam int ELO_V      = 0;
    localparam int ELO_D      = 1;
    localparam int ELO_PLV_LO = 2;
    localparam int ELO_MAT_LO = 4;
    localparam int ELO_G      = 6;
    localparam int ELO_PPN_LO = 7;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd22;

    // Field order mirrors the ELO_* offsets above (ppn in the top bits, v in bit 0).
    typedef struct packed {
        logic [19:0] ppn;
        logic        g;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic        d;
        logic        v;
    } elo_t;

    function automatic logic is_write_op(input logic [2:0] t);
        return (t == OP_WR) || (t == OP_FILL);
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_fill_ptr.sv
// Round-robin replacement pointer for TLBFILL: advances once per completed FILL
// and wraps from TLBNUM-1 back to entry 0.
module tlb_fill_ptr
    import tlb_op_ctrl_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv_i,
    output logic [IW-1:0] ptr_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == IW'(TLBNUM - 1)) ? '0 : ptr_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: accepts one TLBSRCH/RD/WR/FILL/INVTLB at a time,
// drives the TLB ports for a single EXEC cycle and holds the result until taken.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_type,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_va,
    input  logic [18:0]   csr_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [IW-1:0] csr_index,
    input  logic [5:0]    csr_ps,
    input  logic          csr_ne,
    input  logic [26:0]   csr_elo0,
    input  logic [26:0]   csr_elo1,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [2:0]    resp_type,
    output logic          resp_found,
    output logic [IW-1:0] resp_index,
    output logic          resp_ne,
    output logic [18:0]   resp_vppn,
    output logic [9:0]    resp_asid,
    output logic [5:0]    resp_ps,
    output logic [26:0]   resp_elo0,
    output logic [26:0]   resp_elo1,
    output logic [18:0]   s_vppn,
    output logic          s_va_bit12,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [5:0]    w_ps,
    output logic [18:0]   w_vppn,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_ppn0,
    output logic [1:0]    w_plv0,
    output logic [1:0]    w_mat0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_ppn1,
    output logic [1:0]    w_plv1,
    output logic [1:0]    w_mat1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_ppn0,
    input  logic [1:0]    r_plv0,
    input  logic [1:0]    r_mat0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_ppn1,
    input  logic [1:0]    r_plv1,
    input  logic [1:0]    r_mat1,
    input  logic          r_d1,
    input  logic          r_v1
);

    logic [1:0] state_q, state_d;

    logic [2:0]    op_type_q;
    logic [4:0]    op_inv_op_q;
    logic [9:0]    op_inv_asid_q;
    logic [18:0]   op_inv_va_q;
    logic [18:0]   op_vppn_q;
    logic [9:0]    op_asid_q;
    logic [IW-1:0] op_index_q;
    logic [IW-1:0] op_fill_idx_q;
    logic [5:0]    op_ps_q;
    logic          op_ne_q;
    elo_t          op_elo0_q;
    elo_t          op_elo1_q;

    logic [2:0]    resp_type_q;
    logic          resp_found_q, resp_found_d;
    logic [IW-1:0] resp_index_q, resp_index_d;
    logic          resp_ne_q, resp_ne_d;
    logic [18:0]   resp_vppn_q, resp_vppn_d;
    logic [9:0]    resp_asid_q, resp_asid_d;
    logic [5:0]    resp_ps_q, resp_ps_d;
    logic [26:0]   resp_elo0_q, resp_elo0_d;
    logic [26:0]   resp_elo1_q, resp_elo1_d;

    logic          accept;
    logic          exec;
    logic [IW-1:0] fill_ptr;

    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid & op_ready;
    assign exec     = (state_q == ST_EXEC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op_valid)   state_d = ST_EXEC;
            ST_EXEC:                 state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    tlb_fill_ptr #(.TLBNUM(TLBNUM)) u_fill_ptr (
        .clk   (clk),
        .reset (reset),
        .adv_i (exec && (op_type_q == OP_FILL)),
        .ptr_o (fill_ptr)
    );

    // The fill slot is captured with the operands so w_index stays put after the pointer advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_type_q     <= '0;
            op_inv_op_q   <= '0;
            op_inv_asid_q <= '0;
            op_inv_va_q   <= '0;
            op_vppn_q     <= '0;
            op_asid_q     <= '0;
            op_index_q    <= '0;
            op_fill_idx_q <= '0;
            op_ps_q       <= '0;
            op_ne_q       <= 1'b0;
            op_elo0_q     <= '0;
            op_elo1_q     <= '0;
        end else if (accept) begin
            op_type_q     <= op_type;
            op_inv_op_q   <= inv_op;
            op_inv_asid_q <= inv_asid;
            op_inv_va_q   <= inv_va;
            op_vppn_q     <= csr_vppn;
            op_asid_q     <= csr_asid;
            op_index_q    <= csr_index;
            op_fill_idx_q <= fill_ptr;
            op_ps_q       <= csr_ps;
            op_ne_q       <= csr_ne;
            op_elo0_q     <= elo_t'(csr_elo0);
            op_elo1_q     <= elo_t'(csr_elo1);
        end
    end

    // TLB-side drives follow the operand register; only the strobes are gated to EXEC.
    assign s_vppn       = (op_type_q == OP_INV) ? op_inv_va_q : op_vppn_q;
    assign s_asid       = (op_type_q == OP_INV) ? op_inv_asid_q : op_asid_q;
    assign s_va_bit12   = 1'b0;
    assign invtlb_op    = op_inv_op_q;
    assign invtlb_valid = exec & ~reset & (op_type_q == OP_INV) & (op_inv_op_q <= INVTLB_OP_MAX);
    assign we           = exec & ~reset & is_write_op(op_type_q);
    assign w_index      = (op_type_q == OP_FILL) ? op_fill_idx_q : op_index_q;
    assign w_e          = ~op_ne_q;
    assign w_ps         = op_ps_q;
    assign w_vppn       = op_vppn_q;
    assign w_asid       = op_asid_q;
    assign w_g          = op_elo0_q.g & op_elo1_q.g;
    assign w_ppn0       = op_elo0_q.ppn;
    assign w_plv0       = op_elo0_q.plv;
    assign w_mat0       = op_elo0_q.mat;
    assign w_d0         = op_elo0_q.d;
    assign w_v0         = op_elo0_q.v;
    assign w_ppn1       = op_elo1_q.ppn;
    assign w_plv1       = op_elo1_q.plv;
    assign w_mat1       = op_elo1_q.mat;
    assign w_d1         = op_elo1_q.d;
    assign w_v1         = op_elo1_q.v;
    assign r_index      = op_index_q;

    // A SRCH miss keeps the last hit index; reserved ops clear everything.
    always_comb begin
        resp_found_d = 1'b0;
        resp_index_d = resp_index_q;
        resp_ne_d    = 1'b0;
        resp_vppn_d  = '0;
        resp_asid_d  = '0;
        resp_ps_d    = '0;
        resp_elo0_d  = '0;
        resp_elo1_d  = '0;
        case (op_type_q)
            OP_SRCH: begin
                resp_found_d = s_found;
                if (s_found) begin
                    resp_index_d = s_index;
                end
            end
            OP_RD: begin
                resp_ne_d = ~r_e;
                if (r_e) begin
                    resp_vppn_d = r_vppn;
                    resp_asid_d = r_asid;
                    resp_ps_d   = r_ps;
                    resp_elo0_d = {r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                    resp_elo1_d = {r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1};
                end
            end
            OP_WR, OP_FILL, OP_INV: begin
            end
            default: resp_index_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_type_q  <= '0;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_ne_q    <= 1'b0;
            resp_vppn_q  <= '0;
            resp_asid_q  <= '0;
            resp_ps_q    <= '0;
            resp_elo0_q  <= '0;
            resp_elo1_q  <= '0;
        end else if (exec) begin
            resp_type_q  <= op_type_q;
            resp_found_q <= resp_found_d;
            resp_index_q <= resp_index_d;
            resp_ne_q    <= resp_ne_d;
            resp_vppn_q  <= resp_vppn_d;
            resp_asid_q  <= resp_asid_d;
            resp_ps_q    <= resp_ps_d;
            resp_elo0_q  <= resp_elo0_d;
            resp_elo1_q  <= resp_elo1_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_type  = resp_type_q;
    assign resp_found = resp_found_q;
    assign resp_index = resp_index_q;
    assign resp_ne    = resp_ne_q;
    assign resp_vppn  = resp_vppn_q;
    assign resp_asid  = resp_asid_q;
    assign resp_ps    = resp_ps_q;
    assign resp_elo0  = resp_elo0_q;
    assign resp_elo1  = resp_elo1_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: a behavioural TLB sits on the TLB ports and a
// reference model predicts write/invalidate strobes and every response.
module tb_tlb_op_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [26:0] elo0;
        logic [26:0] elo1;
    } ent_t;

    typedef struct packed {
        logic [2:0]    t;
        logic [4:0]    iop;
        logic [9:0]    iasid;
        logic [18:0]   iva;
        logic [18:0]   vppn;
        logic [9:0]    asid;
        logic [IW-1:0] idx;
        logic [5:0]    ps;
        logic          ne;
        logic [26:0]   e0;
        logic [26:0]   e1;
    } op_t;

    logic clk, reset, op_valid, op_ready, resp_valid, resp_ready;
    logic [2:0] op_type, resp_type;
    logic [4:0] inv_op, invtlb_op;
    logic [9:0] inv_asid, csr_asid, resp_asid, s_asid, w_asid, r_asid;
    logic [18:0] inv_va, csr_vppn, resp_vppn, s_vppn, w_vppn, r_vppn;
    logic [IW-1:0] csr_index, resp_index, s_index, w_index, r_index;
    logic [5:0] csr_ps, resp_ps, w_ps, r_ps;
    logic csr_ne, resp_found, resp_ne, s_va_bit12, s_found, invtlb_valid;
    logic [26:0] csr_elo0, csr_elo1, resp_elo0, resp_elo1;
    logic we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
    logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
    logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;

    tlb_op_ctrl #(.TLBNUM(N)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_index(csr_index), .csr_ps(csr_ps),
        .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_type(resp_type),
        .resp_found(resp_found), .resp_index(resp_index), .resp_ne(resp_ne),
        .resp_vppn(resp_vppn), .resp_asid(resp_asid), .resp_ps(resp_ps),
        .resp_elo0(resp_elo0), .resp_elo1(resp_elo1),
        .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_e(w_e), .w_ps(w_ps), .w_vppn(w_vppn), .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit match(input ent_t e, input logic [18:0] vppn, input logic [9:0] asid);
        return e.e && (e.g || (e.asid == asid)) && (e.vppn[18:9] == vppn[18:9]) &&
               ((e.ps == 6'd22) || (e.vppn[8:0] == vppn[8:0]));
    endfunction

    // Behavioural TLB attached to the DUT's search/read/write ports.
    ent_t tlb_mem [N];
    ent_t rd_ent;
    logic mem_clr;

    always_comb begin
        s_found = 1'b0;
        s_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match(tlb_mem[i], s_vppn, s_asid)) begin
                s_found = 1'b1;
                s_index = IW'(i);
            end
        end
    end

    always_comb begin
        rd_ent = tlb_mem[r_index];
        r_e = rd_ent.e; r_vppn = rd_ent.vppn; r_ps = rd_ent.ps; r_asid = rd_ent.asid; r_g = rd_ent.g;
        r_ppn0 = rd_ent.elo0[26:7]; r_mat0 = rd_ent.elo0[5:4]; r_plv0 = rd_ent.elo0[3:2];
        r_d0 = rd_ent.elo0[1]; r_v0 = rd_ent.elo0[0];
        r_ppn1 = rd_ent.elo1[26:7]; r_mat1 = rd_ent.elo1[5:4]; r_plv1 = rd_ent.elo1[3:2];
        r_d1 = rd_ent.elo1[1]; r_v1 = rd_ent.elo1[0];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < N; i++) tlb_mem[i] <= '0;
        end else if (we) begin
            tlb_mem[w_index] <= '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                                  elo0: {w_ppn0, w_g, w_mat0, w_plv0, w_d0, w_v0},
                                  elo1: {w_ppn1, w_g, w_mat1, w_plv1, w_d1, w_v1}};
        end
    end

    // Reference model state: architectural TLB contents, FILL pointer, last SRCH hit.
    ent_t          ref_mem [N];
    int            ref_fill;
    logic [IW-1:0] ref_last;
    logic [127:0]  exp_wq [$];
    logic [127:0]  exp_iq [$];
    logic [127:0]  exp_rq [$];
    int            acc_q [$];

    task automatic model(input op_t o);
        logic          found = 1'b0;
        logic          ne_o = 1'b0;
        logic [18:0]   vppn_o = '0;
        logic [9:0]    asid_o = '0;
        logic [5:0]    ps_o = '0;
        logic [26:0]   e0_o = '0, e1_o = '0;
        logic [IW-1:0] widx;
        logic          g;
        ent_t          ent;
        case (o.t)
            3'd0: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (match(ref_mem[i], o.vppn, o.asid)) begin
                        found = 1'b1;
                        widx  = IW'(i);
                    end
                end
                if (found) ref_last = widx;
            end
            3'd1: begin
                ent  = ref_mem[o.idx];
                ne_o = ~ent.e;
                if (ent.e) begin
                    vppn_o = ent.vppn; asid_o = ent.asid; ps_o = ent.ps; e0_o = ent.elo0; e1_o = ent.elo1;
                end
            end
            3'd2, 3'd3: begin
                widx = (o.t == 3'd3) ? IW'(ref_fill) : o.idx;
                g    = o.e0[6] & o.e1[6];
                ref_mem[widx] = '{e: ~o.ne, vppn: o.vppn, ps: o.ps, asid: o.asid, g: g,
                                  elo0: {o.e0[26:7], g, o.e0[5:0]}, elo1: {o.e1[26:7], g, o.e1[5:0]}};
                exp_wq.push_back({widx, ~o.ne, o.ps, o.vppn, o.asid, g,
                                  o.e0[26:7], o.e0[3:2], o.e0[5:4], o.e0[1], o.e0[0],
                                  o.e1[26:7], o.e1[3:2], o.e1[5:4], o.e1[1], o.e1[0]});
                if (o.t == 3'd3) ref_fill = (ref_fill + 1) % N;
            end
            3'd4: if (o.iop <= 5'd6) exp_iq.push_back({o.iop, o.iasid, o.iva});
            default: ref_last = '0;
        endcase
        exp_rq.push_back({o.t, found, ref_last, ne_o, vppn_o, asid_o, ps_o, e0_o, e1_o});
    endtask

    logic hold_low = 1'b0;
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: strobes, response latency, stability while stalled, and scoreboard pops.
    int           cyc = 0;
    logic         prev_v = 1'b0, prev_hs = 1'b0;
    logic [127:0] prev_resp = '0;
    logic [127:0] cur_resp;
    always @(negedge clk) begin
        cyc++;
        cur_resp = {resp_type, resp_found, resp_index, resp_ne, resp_vppn, resp_asid, resp_ps, resp_elo0, resp_elo1};
        if (reset) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (op_valid && op_ready) acc_q.push_back(cyc);
            if (we) begin
                if (exp_wq.size() == 0) chk("unexpected_we", 1, 0);
                else chk("write_drive", {w_index, w_e, w_ps, w_vppn, w_asid, w_g,
                                         w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
                                         w_ppn1, w_plv1, w_mat1, w_d1, w_v1}, exp_wq.pop_front());
            end
            if (invtlb_valid) begin
                if (exp_iq.size() == 0) chk("unexpected_invtlb", 1, 0);
                else chk("invtlb_drive", {invtlb_op, s_asid, s_vppn}, exp_iq.pop_front());
            end
            if (resp_valid) begin
                if (!prev_v) begin
                    if (acc_q.size() == 0) chk("resp_without_accept", 1, 0);
                    else chk("latency", 128'(cyc - acc_q.pop_front()), 2);
                end else if (!prev_hs) begin
                    chk("resp_stable", cur_resp, prev_resp);
                end
                if (resp_ready) begin
                    if (exp_rq.size() == 0) chk("unexpected_resp", 1, 0);
                    else chk("response", cur_resp, exp_rq.pop_front());
                end
            end
            prev_v    = resp_valid;
            prev_hs   = resp_valid && resp_ready;
            prev_resp = cur_resp;
        end
    end

    function automatic op_t rnd_op();
        op_t o;
        o.t     = 3'($urandom_range(0, 7));
        o.iop   = 5'($urandom_range(0, 9));
        o.iasid = 10'($urandom);
        o.iva   = 19'($urandom);
        o.vppn  = ($urandom_range(0, 1) == 1) ? ref_mem[$urandom_range(0, N - 1)].vppn : 19'($urandom);
        o.asid  = 10'($urandom_range(0, 3));
        o.idx   = IW'($urandom_range(0, N - 1));
        o.ps    = ($urandom_range(0, 1) == 1) ? 6'd12 : 6'd22;
        o.ne    = ($urandom_range(0, 3) == 0);
        o.e0    = 27'($urandom);
        o.e1    = 27'($urandom);
        return o;
    endfunction

    task automatic issue(input op_t o, input bit upd);
        int n = 0;
        @(posedge clk);
        #1;
        op_type = o.t; inv_op = o.iop; inv_asid = o.iasid; inv_va = o.iva;
        csr_vppn = o.vppn; csr_asid = o.asid; csr_index = o.idx; csr_ps = o.ps;
        csr_ne = o.ne; csr_elo0 = o.e0; csr_elo1 = o.e1;
        op_valid = 1'b1;
        while (!op_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!op_ready) begin
            $display("FAIL accept_timeout actual=%0d expected=1", op_ready);
            $fatal(1, "op_ready never asserted");
        end
        if (upd) model(o);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_rq.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_rq.size() != 0) chk("drain_timeout", 128'(exp_rq.size()), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    op_t o;
    initial begin
        op_valid = 1'b0; op_type = '0; inv_op = '0; inv_asid = '0; inv_va = '0;
        csr_vppn = '0; csr_asid = '0; csr_index = '0; csr_ps = '0; csr_ne = 1'b0;
        csr_elo0 = '0; csr_elo1 = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        ref_fill = 0;
        ref_last = '0;
        mem_clr = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_op_ready", op_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_we", we, 0);
        chk("reset_invtlb", invtlb_valid, 0);
        chk("reset_resp_fields", {resp_type, resp_found, resp_index, resp_ne, resp_vppn,
                                  resp_asid, resp_ps, resp_elo0, resp_elo1}, 0);
        reset = 1'b0;
        mem_clr = 1'b0;

        // 17 FILLs with a WR and RD in the middle; entry 7 is filled invalid.
        for (int k = 0; k < 17; k++) begin
            if (k == 8) begin
                o = rnd_op(); o.t = 3'd2; o.idx = 4'd3; o.vppn = {2'b11, 17'($urandom)};
                issue(o, 1);
                o = rnd_op(); o.t = 3'd1; o.idx = 4'd2;
                issue(o, 1);
            end
            o = rnd_op(); o.t = 3'd3; o.vppn = {2'b11, 17'($urandom)}; o.ne = (k == 7);
            issue(o, 1);
        end

        o = rnd_op(); o.t = 3'd2; o.idx = 4'd5; o.vppn = 19'h12345; o.ps = 6'd12; o.ne = 1'b0;
        o.asid = 10'h055;
        o.e0 = {20'hABCDE, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1};
        o.e1 = {20'h13579, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1};
        issue(o, 1);
        o = rnd_op(); o.t = 3'd0; o.vppn = 19'h12345; o.asid = 10'h3A7;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd0; o.vppn = 19'h5A5A5;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd1; o.idx = 4'd5;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd1; o.idx = 4'd7;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd4; o.iop = 5'd7;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd4; o.iop = 5'd4; o.iasid = 10'd3;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd6;
        issue(o, 1);
        drain();

        // Response held back for 4 cycles.
        hold_low = 1'b1;
        o = rnd_op(); o.t = 3'd1; o.idx = 4'd5;
        issue(o, 1);
        for (int n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("stall_op_ready", op_ready, 0);
            chk("stall_resp_valid", resp_valid, 1);
        end
        hold_low = 1'b0;
        drain();

        // Reset lands in the EXEC cycle of a WR: no write, no response.
        o = rnd_op(); o.t = 3'd2; o.idx = 4'd9; o.ne = 1'b0;
        issue(o, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_exec_we", we, 0);
        chk("rst_exec_invtlb", invtlb_valid, 0);
        chk("rst_exec_idle", op_ready, 1);
        chk("rst_exec_resp_valid", resp_valid, 0);
        #1;
        reset = 1'b0;
        acc_q.delete();
        ref_fill = 0;
        ref_last = '0;
        o = rnd_op(); o.t = 3'd1; o.idx = 4'd9;
        issue(o, 1);
        o = rnd_op(); o.t = 3'd3;
        issue(o, 1);

        for (int k = 0; k < 300; k++) begin
            o = rnd_op();
            issue(o, 1);
        end
        drain();

        chk("pending_writes", 128'(exp_wq.size()), 0);
        chk("pending_invtlb", 128'(exp_iq.size()), 0);
        chk("pending_resps", 128'(exp_rq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, the number of TLB entries; IW = $clog2(TLBNUM).
REQ-002 SHALL use one clock and an asynchronous, active-high reset; the clock and reset ports are listed first below.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op_valid / op_ready  input / output  1 / 1  instruction request handshake.
REQ-006 op_type  input  3  operation: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 are reserved.
REQ-007 inv_op / inv_asid / inv_va  input  5 / 10 / 19  INVTLB op code, rj ASID, and rk VA[31:13].
REQ-008 csr_vppn / csr_asid / csr_index / csr_ps / csr_ne  input  19 / 10 / IW / 6 / 1  TLBEHI, ASID, and TLBIDX fields.
REQ-009 csr_elo0 / csr_elo1  input  27 / 27  each packed as {ppn[26:7], g[6], mat[5:4], plv[3:2], d[1], v[0]}.
REQ-010 resp_valid / resp_ready  output / input  1 / 1  result handshake.
REQ-011 resp_type  output  3  op_type of the completed operation.
REQ-012 resp_found / resp_index  output  1 / IW  SRCH result.
REQ-013 resp_ne / resp_vppn / resp_asid / resp_ps / resp_elo0 / resp_elo1  output  1 / 19 / 10 / 6 / 27 / 27  RD result.
REQ-014 s_vppn / s_va_bit12 / s_asid  output  19 / 1 / 10  TLB search port 1 drive.
REQ-015 s_found / s_index  input  1 / IW  TLB search port 1 return.
REQ-016 invtlb_valid / invtlb_op  output  1 / 5  TLB invalidate drive.
REQ-017 we / w_index / w_e / w_ps / w_vppn / w_asid / w_g  output  1 / IW / 1 / 6 / 19 / 10 / 1  TLB write drive.
REQ-018 w_ppn0-1 / w_plv0-1 / w_mat0-1 / w_d0-1 / w_v0-1  output  20 / 2 / 2 / 1 / 1 each  TLB write page fields.
REQ-019 r_index  output  IW  TLB read index.
REQ-020 r_e / r_vppn / r_ps / r_asid / r_g / r_ppn0-1 / r_plv0-1 / r_mat0-1 / r_d0-1 / r_v0-1  input  TLB read return, same widths as the write fields.

Function
REQ-021 SHALL implement an FSM with states IDLE, EXEC, and RESP; op_ready = (state==IDLE).
REQ-022 IDLE: op_valid & op_ready SHALL latch op_type, the CSR inputs, and the inv inputs into an operand register, then go to EXEC.
REQ-023 EXEC lasts exactly 1 cycle; TLB-side drives come combinationally from the operand register; at its end the results are registered and the FSM goes to RESP.
REQ-024 RESP: resp_valid=1 and resp_* stay stable until resp_ready; on the resp_valid & resp_ready cycle the FSM goes to IDLE; minimum latency is accept to resp_valid = 2 cycles.
REQ-025 SRCH SHALL drive s_vppn=csr_vppn, s_asid=csr_asid, s_va_bit12=0; resp_found=s_found; resp_index=s_index when found, else the index is held at its previous value.
REQ-026 RD SHALL drive r_index=csr_index and set resp_ne=~r_e.
REQ-027 RD with r_e=1 SHALL set resp_vppn/asid/ps=r_*, and each elo = {ppn, r_g, mat, plv, d, v}.
REQ-028 RD with r_e=0 SHALL zero resp_vppn, resp_asid, resp_ps, resp_elo0, and resp_elo1.
REQ-029 WR/FILL SHALL assert we for exactly the EXEC cycle, with w_e=~csr_ne, w_ps=csr_ps, w_vppn=csr_vppn, and w_asid=csr_asid.
REQ-030 WR/FILL SHALL set w_g = elo0.g & elo1.g and take the page-0/1 fields from elo0/elo1.
REQ-031 WR SHALL set w_index=csr_index; FILL SHALL set w_index=fill_ptr.
REQ-032 fill_ptr is an IW-bit counter: it increments by 1 when each FILL's EXEC completes, wraps from TLBNUM-1 to 0, and is not advanced by any other op.
REQ-033 INV SHALL pulse invtlb_valid for the EXEC cycle with invtlb_op=inv_op, s_asid=inv_asid, and s_vppn=inv_va.
REQ-034 INV with inv_op>6 SHALL NOT pulse invtlb_valid, but SHALL still respond.
REQ-035 Reserved op_type values SHALL produce no TLB-side activity and SHALL respond with all result fields 0.
REQ-036 Outside EXEC, we=0 and invtlb_valid=0; all other drives hold their last operand values.
REQ-037 op_valid SHALL be ignored outside IDLE; at most one operation is in flight.

Reset
REQ-038 Reset SHALL force state=IDLE, fill_ptr=0, resp_valid=0, and all resp_* registers and the operand register to 0; we and invtlb_valid SHALL be 0 during reset.
REQ-039 Reset asserted during EXEC SHALL suppress that cycle's we and invtlb_valid; the operation is discarded and produces no response.

Structure
REQ-040 A shared package SHALL hold the op_type encodings, the state encoding, the INVTLB op limit (6), the ELO field offsets, and the ps constants 12 and 22.
REQ-041 SHALL instantiate one sub-module, tlb_fill_ptr (the wrap counter); everything else is flat.

Verification
REQ-042 WR with index=5, vppn=0x12345, ps=12, ne=0, and elo g bits 1/1 -> one-cycle we, w_index=5, w_e=1, w_g=1; resp_valid 2 cycles after accept.
REQ-043 Follow REQ-042 with SRCH, vppn=0x12345, asid arbitrary -> resp_found=1, resp_index=5; a SRCH on an unwritten VA -> resp_found=0.
REQ-044 RD index=5 -> resp_ne=0 with fields echoing REQ-042; RD of an index with e=0 -> resp_ne=1 and all fields 0.
REQ-045 17 consecutive FILLs from reset -> w_index sequence 0,1,...,15,0; WR and RD in between do not change fill_ptr.
REQ-046 INV op=7 -> no invtlb_valid, response returned; INV op=4 with asid=3 -> one-cycle invtlb_valid with s_asid=3.
REQ-047 resp_ready held low for 4 cycles -> resp_* stable and op_ready=0 throughout; reset asserted during EXEC of a WR -> no we, state=IDLE.
